inst_mem_loadable: RTL
======================

# inst_mem_loadable

Parametrised, word-addressed instruction memory for the ARM pipeline's IF stage, replacing the hard-coded program ROM. After reset it accepts a program over a valid/ready load port, then serves fetches through a synchronous, one-cycle read port with freeze (stall) and flush support. The IF stage drives `pc` and consumes `inst`/`inst_valid`.

## Interface

**Parameters**
- `WORD_WIDTH`, 32, instruction width in bits.
- `DEPTH`, 1024, memory depth in words; must be ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`, width of the loaded-word counter.

**Ports**
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  byte address from IF.
- `freeze`  in  1  hazard stall; holds the fetch output.
- `flush`  in  1  branch taken; kills the fetch output.
- `inst`  out  WORD_WIDTH  fetched instruction (registered).
- `inst_valid`  out  1  `inst` is a real fetch.
- `ld_valid`  in  1  loader has a word.
- `ld_ready`  out  1  memory accepts a word.
- `ld_data`  in  WORD_WIDTH  program word.
- `ld_last`  in  1  marks the final program word.
- `reload`  in  1  single-cycle request to re-enter LOAD.
- `loaded`  out  CNT_W  number of words written in the current load.
- `running`  out  1  high in RUN.

## Operation

**States:** LOAD, RUN.

**LOAD**
- `ld_ready` = (`loaded` < `DEPTH`).
- A handshake (`ld_valid` & `ld_ready`) writes `ld_data` to `mem[loaded]` and increments `loaded`.
- Handshake with `ld_last`=1 → RUN.
- If `loaded` reaches `DEPTH` with no `ld_last` → RUN on the following edge.
- `inst`=0, `inst_valid`=0 throughout.

**RUN**
- `ld_ready`=0; `ld_valid` is ignored.
- Word index = `pc[31:2]`. Without `INST_MEM_FAULT_EN`, the index is taken modulo `DEPTH`; `pc[1:0]` is ignored.
- Each edge, in priority order:
  - `flush` → `inst`=0, `inst_valid`=0.
  - else `freeze` → hold `inst` and `inst_valid`.
  - else → `inst` = `mem[index]`, `inst_valid`=1.
- Words never written since power-up read as X. The bench loads every address it fetches.

**Reload**
- `reload`=1 in any state → LOAD on the next edge, with `loaded`=0, `inst`=0 and `inst_valid`=0.
- Memory contents are retained until overwritten.
- `reload` has priority over a simultaneous load handshake: the word is dropped and not written.

**Reset**
- `rst` → LOAD, `loaded`=0, `inst`=0, `inst_valid`=0, `running`=0.
- The memory array is not reset.
- Reset asserted mid-load aborts the load; the words already written persist.

## Timing

- Read latency: 1 cycle. `pc` sampled at edge N appears on `inst` after edge N.
- Write-to-read: a word written at edge N is readable by a fetch sampled at edge N+1 or later.
- LOAD→RUN: the edge that accepts `ld_last` sets `running`=1. The first fetch is sampled on the next edge, so `inst_valid` first rises one edge after `running`.
- `ld_ready` is a registered function of state and `loaded`; it has no combinational path from `ld_valid`.
- Loader throughput: one word per cycle.
- `freeze` and `flush` are sampled only at clock edges. Asserting both acts as `flush`.

## Configuration

**`INST_MEM_FAULT_EN`**
- **Defined:**
  - Adds output `fetch_fault` (1 bit, reset 0).
  - In RUN, a fetch with `pc[1:0]`≠0 or `pc[31:2]` ≥ `DEPTH` gives `inst`=0, `inst_valid`=0 and `fetch_fault`=1 for that cycle. The memory is not read.
  - `fetch_fault` follows the same flush/freeze priority as `inst`.
- **Undefined:** the port is absent; addresses wrap modulo `DEPTH` and `pc[1:0]` is ignored.

## Test plan

1. **Reset and load:** `rst` → `inst`=0, `inst_valid`=0, `ld_ready`=1, `running`=0. Load 3 words (0xE3A00014, 0xE3A01A01, 0xEAFFFFFF; last on the third) → `loaded`=3 and `running`=1 on the third edge.
2. **Fetch:** `pc`=0,4,8 on consecutive edges → `inst` = 0xE3A00014, 0xE3A01A01, 0xEAFFFFFF, each one cycle later, with `inst_valid`=1.
3. **Freeze and flush:** with `pc`=4, `freeze`=1 for 3 cycles → `inst` held at the prior word. Then `flush`=`freeze`=1 → `inst`=0, `inst_valid`=0. Then release both → 0xE3A01A01.
4. **Full memory and wrap:** `DEPTH`=4; load 4 words with no `ld_last` → `ld_ready`=0 and RUN. Without the macro, `pc`=16 → `mem[0]`. With the macro, `pc`=16 or `pc`=2 → `fetch_fault`=1, `inst_valid`=0.
5. **Reload mid-run:** `reload` pulse in RUN → `running`=0, `loaded`=0, `inst_valid`=0 next cycle. Load 1 new word 0xE1A00000 with last → `pc`=0 fetches 0xE1A00000 and `pc`=4 returns the old word.
6. **Async reset mid-load:** assert `rst` between clock edges after 2 words → outputs reset immediately. Reload 1 word → `loaded`=1 and earlier `mem[1]` is preserved.

Source files
------------

// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: word-addressed instruction memory for the IF stage.
// After reset the memory takes a program over a valid/ready load port
// (LOAD), then serves one-cycle registered fetches with freeze and flush
// (RUN). A single-cycle reload pulse returns it to LOAD at any time.
// Optional feature macro: INST_MEM_FAULT_EN adds a fetch_fault output and
// rejects misaligned or out-of-range fetches instead of wrapping them.
module inst_mem_loadable #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc,
   input  logic                  freeze,
   input  logic                  flush,
   output logic [WORD_WIDTH-1:0] inst,
   output logic                  inst_valid,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [WORD_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   input  logic                  reload,
   output logic [CNT_W-1:0]      loaded,
   output logic                  running
`ifdef INST_MEM_FAULT_EN
   ,output logic                 fetch_fault
`endif
);

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic {
      S_LOAD,
      S_RUN
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  ld_fire;
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [29:0]           word_addr;
   logic [IDX_W-1:0]      rd_idx;
   logic [WORD_WIDTH-1:0] mem [DEPTH];

   // ld_ready and running depend only on registered state and the
   // counter, so the loader never sees a combinational path from ld_valid.
   assign ld_ready  = (state_q == S_LOAD) && (loaded < DEPTH_C);
   assign running   = (state_q == S_RUN);
   assign ld_fire   = ld_valid && ld_ready;
   // A reload in the same cycle as a handshake drops the offered word.
   assign wr_en     = ld_fire && !reload;
   assign wr_idx    = loaded[IDX_W-1:0];

   // Fetch address: word index from pc[31:2], wrapped into the array.
   assign word_addr = pc[31:2];
   assign rd_idx    = IDX_W'({2'b00, word_addr} % 32'(DEPTH));

`ifdef INST_MEM_FAULT_EN
   logic addr_fault;
   assign addr_fault = (pc[1:0] != 2'b00) || ({2'b00, word_addr} >= 32'(DEPTH));
`else
   // Byte offset is deliberately ignored when fetches wrap.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^pc[1:0];
`endif

   // Next-state logic: LOAD leaves on the last word or on a full array,
   // reload returns to LOAD from either state.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      state_d = state_q;
      case (state_q)
         S_LOAD: begin
            if (ld_fire && ld_last) begin
               state_d = S_RUN;
            end else if (loaded == DEPTH_C) begin
               state_d = S_RUN;
            end
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_LOAD;
      endcase
      if (reload) begin
         state_d = S_LOAD;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Loaded-word counter: cleared by reset/reload, bumped per accepted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loaded <= '0;
      end else if (reload) begin
         loaded <= '0;
      end else if (wr_en) begin
         loaded <= loaded + 1'b1;
      end
   end

   // Program storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; contents survive reset and reload
      // and are only changed by a load handshake.
      if (wr_en) begin
         mem[wr_idx] <= ld_data;
      end
   end

   // Registered fetch port with flush > freeze > fetch priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst        <= '0;
         inst_valid  <= 1'b0;
`ifdef INST_MEM_FAULT_EN
         fetch_fault <= 1'b0;
`endif
      end else if (reload || (state_q != S_RUN) || flush) begin
         inst        <= '0;
         inst_valid  <= 1'b0;
`ifdef INST_MEM_FAULT_EN
         fetch_fault <= 1'b0;
`endif
      end else if (!freeze) begin
`ifdef INST_MEM_FAULT_EN
         if (addr_fault) begin
            inst        <= '0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b1;
         end else begin
            inst        <= mem[rd_idx];
            inst_valid  <= 1'b1;
            fetch_fault <= 1'b0;
         end
`else
         inst       <= mem[rd_idx];
         inst_valid <= 1'b1;
`endif
      end
   end

endmodule
